step_silencer: RTL and testbench

- Rate-limits per-transducer duty and phase commands so the outputs move toward their targets by at most STEP per update epoch.
- Phase slews along the shortest path modulo that transducer's CYCLE. Duty slews linearly with no wrap.
- Sits between the modulation/gain stage and the PWM generators.
- One shared arithmetic unit is time-multiplexed over the DEPTH channels, with epochs paced by SYS_TIME.

---
 rtl/silencer_pkg.sv | 18 +
 rtl/silencer_step_unit.sv | 70 +++++++
 rtl/step_silencer.sv | 128 ++++++++++++
 tb/tb_step_silencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/silencer_pkg.sv
// silencer_pkg: shared defaults, types and the epoch time test
// for the step silencer.
package silencer_pkg;

    localparam int DEF_WIDTH = 13;
    localparam int DEF_DEPTH = 249;

    typedef logic signed [DEF_WIDTH+1:0] diff_t;
    typedef logic [15:0] time_t;

    // Wrap-safe "now has reached due" over a 16-bit free-running clock
    function automatic logic time_reached(time_t now, time_t due);
        time_t gap;
        gap = now - due;
        return ~gap[15];
    endfunction

endpackage

// File: rtl/silencer_step_unit.sv
// silencer_step_unit: one combinational rate-limited step toward a target.
// Define SILENCER_BYPASS_EN to make a zero step copy the target directly.
module silencer_step_unit
    import silencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] cyc,
    input  logic [WIDTH-1:0] step,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt
);

    localparam int DW = WIDTH + 2;
    typedef logic signed [DW-1:0] sdiff_t;

    sdiff_t c;
    sdiff_t s;
    sdiff_t d_raw;
    sdiff_t d2;
    sdiff_t d;
    sdiff_t mag;
    sdiff_t p_raw;
    sdiff_t p;
    logic   bypass;

`ifdef SILENCER_BYPASS_EN
    assign bypass = (step == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        c     = sdiff_t'({2'b00, cyc});
        s     = sdiff_t'({2'b00, step});
        d_raw = sdiff_t'({2'b00, tgt}) - sdiff_t'({2'b00, cur});
        d2    = d_raw <<< 1;
        d     = d_raw;
        // Phase takes the short way round; an exact half-cycle goes positive
        if (mode) begin
            if (d2 > c) begin
                d = d_raw - c;
            end else if (d2 <= -c) begin
                d = d_raw + c;
            end
        end
        mag = d[DW-1] ? -d : d;
        if (d[DW-1]) begin
            p_raw = sdiff_t'({2'b00, cur}) - s;
        end else begin
            p_raw = sdiff_t'({2'b00, cur}) + s;
        end
        p = p_raw;
        if (mode) begin
            if (p_raw[DW-1]) begin
                p = p_raw + c;
            end else if (p_raw >= c) begin
                p = p_raw - c;
            end
        end
        if (bypass || (mag <= s)) begin
            nxt = tgt;
        end else begin
            nxt = p[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/step_silencer.sv
// step_silencer: time-multiplexed duty/phase slew limiter, one channel per clock.
// Define SILENCER_BYPASS_EN to make STEP == 0 pass targets straight through.
module step_silencer
    import silencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [63:0]      SYS_TIME,
    input  logic [15:0]      CYCLE_S,
    input  logic [WIDTH-1:0] STEP,
    input  logic [WIDTH-1:0] CYCLE   [DEPTH],
    input  logic [WIDTH-1:0] DUTY    [DEPTH],
    input  logic [WIDTH-1:0] PHASE   [DEPTH],
    output logic [WIDTH-1:0] DUTY_S  [DEPTH],
    output logic [WIDTH-1:0] PHASE_S [DEPTH],
    output logic             DONE
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_TAIL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    time_t            next_time;
    logic             reached;
    logic             start;
    logic             write;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH-1:0] phase_nxt;
    logic             unused_time;

    assign unused_time = ^SYS_TIME[63:16];
    assign reached = time_reached(SYS_TIME[15:0], next_time);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Triggers are only looked at in IDLE, so a late one waits for the epoch to end
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        write     = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            S_IDLE: begin
                DONE = 1'b1;
                if (reached) begin
                    start     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                write = 1'b1;
                if (idx == LAST) begin
                    state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            next_time <= '0;
            idx       <= '0;
        end else if (start) begin
            next_time <= next_time + CYCLE_S;
            idx       <= '0;
        end else if (write && (idx != LAST)) begin
            idx <= idx + 1'b1;
        end
    end

    silencer_step_unit #(
        .WIDTH(WIDTH)
    ) u_duty (
        .cur (DUTY_S[idx]),
        .tgt (DUTY[idx]),
        .cyc (CYCLE[idx]),
        .step(STEP),
        .mode(1'b0),
        .nxt (duty_nxt)
    );

    silencer_step_unit #(
        .WIDTH(WIDTH)
    ) u_phase (
        .cur (PHASE_S[idx]),
        .tgt (PHASE[idx]),
        .cyc (CYCLE[idx]),
        .step(STEP),
        .mode(1'b1),
        .nxt (phase_nxt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                DUTY_S[i]  <= '0;
                PHASE_S[i] <= '0;
            end
        end else if (write) begin
            DUTY_S[idx]  <= duty_nxt;
            PHASE_S[idx] <= phase_nxt;
        end
    end

endmodule

// File: tb/tb_step_silencer.sv
// tb_step_silencer: vector table, convergence runs and a per-epoch
// scoreboard for step_silencer.
module tb_step_silencer;
    import silencer_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int N = DEF_DEPTH;

    logic         CLK = 1'b0;
    logic         RST;
    logic [63:0]  SYS_TIME;
    logic [15:0]  CYCLE_S;
    logic [W-1:0] STEP;
    logic [W-1:0] cyc_a   [N];
    logic [W-1:0] duty_a  [N];
    logic [W-1:0] phase_a [N];
    logic [W-1:0] duty_s  [N];
    logic [W-1:0] phase_s [N];
    logic         DONE;

    always #5 CLK = ~CLK;

    step_silencer #(
        .WIDTH(W),
        .DEPTH(N)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SYS_TIME(SYS_TIME),
        .CYCLE_S (CYCLE_S),
        .STEP    (STEP),
        .CYCLE   (cyc_a),
        .DUTY    (duty_a),
        .PHASE   (phase_a),
        .DUTY_S  (duty_s),
        .PHASE_S (phase_s),
        .DONE    (DONE)
    );

    typedef struct {
        int ch;
        int duty;
        int phase;
    } exp_t;

    typedef struct {
        string name;
        int cyc;
        int p0, pt, d0, dt, step;
        int pe1, pe2, de1, de2;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[8];
    int          m_duty  [N];
    int          m_phase [N];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] tb_next;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Reference step written straight from the slew rules
    function automatic int model_step(int cur, int tgt, int c, int st, bit ph);
        int d, p, a;
        d = tgt - cur;
        if (ph) begin
            if (2 * d > c) d = d - c;
            else if (2 * d <= -c) d = d + c;
        end
`ifdef SILENCER_BYPASS_EN
        if (st == 0) return tgt;
`endif
        a = (d < 0) ? -d : d;
        if (a <= st) return tgt;
        p = (d > 0) ? cur + st : cur - st;
        if (ph) begin
            if (p < 0) p = p + c;
            else if (p >= c) p = p - c;
        end
        return p;
    endfunction

    task automatic do_reset();
        RST = 1'b0;
        SYS_TIME = 64'h8000;
        tb_next = 16'h0;
        sbq.delete();
        for (int i = 0; i < N; i++) begin
            m_duty[i] = 0;
            m_phase[i] = 0;
        end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic set_all(int c, int d, int p);
        for (int i = 0; i < N; i++) begin
            cyc_a[i] = W'(c);
            duty_a[i] = W'(d);
            phase_a[i] = W'(p);
        end
    endtask

    task automatic run_epoch();
        int wait_n, busy;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = model_step(m_duty[i], int'(duty_a[i]),
                                   int'(cyc_a[i]), int'(STEP), 1'b0);
            m_phase[i] = model_step(m_phase[i], int'(phase_a[i]),
                                    int'(cyc_a[i]), int'(STEP), 1'b1);
            e.ch = i;
            e.duty = m_duty[i];
            e.phase = m_phase[i];
            sbq.push_back(e);
        end
        @(negedge CLK);
        SYS_TIME = {48'h0, tb_next};
        wait_n = 0;
        while (DONE && wait_n < 8) begin
            @(negedge CLK);
            wait_n++;
        end
        check("epoch_start", int'(DONE), 0);
        if (DONE) begin
            sbq.delete();
            return;
        end
        busy = 0;
        while (!DONE && busy < N + 10) begin
            @(negedge CLK);
            busy++;
        end
        check("epoch_busy_len", int'(busy >= N && busy <= N + 3), 1);
        tb_next = tb_next + CYCLE_S;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (int'(duty_s[e.ch]) != e.duty || int'(phase_s[e.ch]) != e.phase) begin
                check($sformatf("sb_duty[%0d]", e.ch), int'(duty_s[e.ch]), e.duty);
                check($sformatf("sb_phase[%0d]", e.ch), int'(phase_s[e.ch]), e.phase);
            end else begin
                n_total++;
                n_pass++;
            end
        end
    endtask

    task automatic run_epochs(int n);
        for (int k = 0; k < n; k++) run_epoch();
    endtask

    task automatic new_targets();
        int c;
        for (int i = 0; i < N; i++) begin
            c = int'(cyc_a[i]);
            duty_a[i] = W'($urandom_range(c, 0));
            phase_a[i] = W'($urandom_range(c - 1, 0));
        end
    endtask

    task automatic check_phase_all(string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_phase[%0d]", tag, i), int'(phase_s[i]), int'(phase_a[i]));
    endtask

    task automatic check_duty_all(string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_duty[%0d]", tag, i), int'(duty_s[i]), int'(duty_a[i]));
    endtask

    initial begin
        int lows;

        vecs[0] = '{"wrap_fwd",  4000, 3950, 50,   3900, 100,  60,  10,   50,   3840, 3780};
        vecs[1] = '{"tie_pos",   4000, 0,    2000, 0,    2000, 100, 100,  200,  100,  200};
        vecs[2] = '{"wrap_back", 4000, 50,   3950, 100,  3900, 60,  3990, 3950, 160,  220};
        vecs[3] = '{"tie_neg",   4000, 2000, 0,    2000, 0,    100, 2100, 2200, 1900, 1800};
        vecs[4] = '{"odd_tie",   4001, 0,    2000, 0,    0,    100, 100,  200,  0,    0};
        vecs[5] = '{"odd_over",  4001, 0,    2001, 10,   10,   100, 3901, 3801, 10,   10};
        vecs[6] = '{"exact",     4000, 100,  200,  100,  200,  100, 200,  200,  200,  200};
`ifdef SILENCER_BYPASS_EN
        vecs[7] = '{"step0",     4000, 100,  300,  100,  300,  0,   300,  300,  300,  300};
`else
        vecs[7] = '{"step0",     4000, 100,  300,  100,  300,  0,   100,  100,  100,  100};
`endif

        CYCLE_S = 16'd4096;
        STEP = W'(100);
        set_all(4096, 4096, 0);
        do_reset();

        check("rst_done", int'(DONE), 1);
        check("rst_duty0", int'(duty_s[0]), 0);
        check("rst_dutyN", int'(duty_s[N-1]), 0);
        check("rst_phase0", int'(phase_s[0]), 0);

        lows = 0;
        repeat (20) begin
            @(negedge CLK);
            if (!DONE) lows++;
        end
        check("no_early_epoch", lows, 0);

        run_epoch();
        check("ramp1_duty0", int'(duty_s[0]), 100);
        check("ramp1_dutyN", int'(duty_s[N-1]), 100);
        run_epochs(39);
        check("ramp40_duty0", int'(duty_s[0]), 4000);
        run_epoch();
        check_duty_all("ramp41");
        check("ramp41_phase0", int'(phase_s[0]), 0);
        check("ramp41_phaseN", int'(phase_s[N-1]), 0);
        lows = 0;
        repeat (5) begin
            @(negedge CLK);
            if (!DONE) lows++;
        end
        check("done_stays_high", lows, 0);
        run_epoch();
        check("ramp_hold_dutyN", int'(duty_s[N-1]), 4096);

        do_reset();
        for (int v = 0; v < 8; v++) begin
            set_all(vecs[v].cyc, vecs[v].d0, vecs[v].p0);
            STEP = W'(8191);
            run_epoch();
            check({vecs[v].name, "_pre_p"}, int'(phase_s[0]), vecs[v].p0);
            check({vecs[v].name, "_pre_d"}, int'(duty_s[N-1]), vecs[v].d0);
            set_all(vecs[v].cyc, vecs[v].dt, vecs[v].pt);
            STEP = W'(vecs[v].step);
            run_epoch();
            check({vecs[v].name, "_p1"}, int'(phase_s[0]), vecs[v].pe1);
            check({vecs[v].name, "_d1"}, int'(duty_s[N-1]), vecs[v].de1);
            run_epoch();
            check({vecs[v].name, "_p2"}, int'(phase_s[N-1]), vecs[v].pe2);
            check({vecs[v].name, "_d2"}, int'(duty_s[0]), vecs[v].de2);
        end

        do_reset();
        STEP = W'(100);
        for (int i = 0; i < N; i++) cyc_a[i] = W'($urandom_range(8000, 2000));
        for (int round = 0; round < 2; round++) begin
            new_targets();
            run_epochs(40);
            check_phase_all($sformatf("rand%0d_e40", round));
            run_epochs(40);
            check_duty_all($sformatf("rand%0d_e80", round));
        end

        set_all(4000, 1000, 1000);
        run_epoch();
        @(negedge CLK);
        SYS_TIME = {48'h0, tb_next};
        repeat (60) @(negedge CLK);
        check("mid_busy", int'(DONE), 0);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_done", int'(DONE), 1);
        check("mid_rst_duty0", int'(duty_s[0]), 0);
        check("mid_rst_dutyN", int'(duty_s[N-1]), 0);
        check("mid_rst_phaseN", int'(phase_s[N-1]), 0);
        do_reset();
        run_epoch();
        check("post_rst_duty0", int'(duty_s[0]), 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
